// File: rtl/pcie_tx_bridge_ptile_if.sv
// Shared types and the AXI4-S TX interface for the P-tile TX bridge.
// Channel bundles are packed so a whole beat moves as one word.
package pcie_tx_bridge_ptile_pkg;
  localparam int NUM_AVST_CH = 2;
  localparam int HDR_W = 128;
  localparam int DATA_W = 256;

  typedef struct packed {
    logic              valid;
    logic              sop;
    logic              eop;
    logic [HDR_W-1:0]  hdr;
    logic [DATA_W-1:0] payload;
  } t_axis_ch;

  typedef t_axis_ch [NUM_AVST_CH-1:0] t_axis_tdata;

  typedef struct packed {
    logic              valid;
    logic              sop;
    logic              eop;
    logic [HDR_W-1:0]  hdr;
    logic [DATA_W-1:0] data;
  } t_avst_tx_ch;

  typedef t_avst_tx_ch [NUM_AVST_CH-1:0] t_avst_txs;
endpackage

interface ofs_fim_pcie_txs_axis_if;
  import pcie_tx_bridge_ptile_pkg::*;
  logic        clk;
  logic        rst_n;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  t_axis_tdata tdata;

  modport slave (
    output clk, rst_n, tready,
    input  tvalid, tlast, tdata
  );
  modport master (
    input  clk, rst_n, tready,
    output tvalid, tlast, tdata
  );
endinterface

// File: rtl/pcie_tx_bridge_ptile.sv
// AXI4-S to P-tile AVST TX bridge: beat FIFO plus ready-latency window.
// Define PCIE_TX_FRAME_CHECK_EN to build in the sop/eop framing checker.
module pcie_tx_bridge_ptile
  import pcie_tx_bridge_ptile_pkg::*;
#(
  parameter int READY_LATENCY = 3,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          avl_clk,
  input  logic                          avl_rst_n,
  ofs_fim_pcie_txs_axis_if.slave        axis_tx_st,
  output t_avst_txs                     avl_tx_st,
  input  logic                          avl_tx_ready,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]              wr_ptr_q, wr_ptr_d;
  logic [AW:0]              rd_ptr_q, rd_ptr_d;
  t_axis_tdata              mem_q [FIFO_DEPTH];
  t_axis_tdata              rd_beat;
  logic [READY_LATENCY-1:0] rdy_pipe_q, rdy_pipe_d;
  logic [READY_LATENCY:0]   rdy_ext;
  t_avst_txs                out_q, out_d;
  logic                     full, empty;
  logic                     accept, any_vld;
  logic                     push, pop, win_nxt;

  assign axis_tx_st.clk   = avl_clk;
  assign axis_tx_st.rst_n = avl_rst_n;

  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
              && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign axis_tx_st.tready = ~full;
  assign accept = axis_tx_st.tvalid & ~full;

  always_comb begin
    any_vld = 1'b0;
    for (int c = 0; c < NUM_AVST_CH; c++) begin
      any_vld = any_vld | axis_tx_st.tdata[c].valid;
    end
  end

  assign push = accept & any_vld;

  // Pop decides on the window of the cycle the beat will be shown in.
  assign rdy_ext    = {rdy_pipe_q, avl_tx_ready};
  assign rdy_pipe_d = rdy_ext[READY_LATENCY-1:0];
  assign win_nxt    = rdy_pipe_d[READY_LATENCY-1];
  assign pop        = win_nxt & ~empty;

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  assign rd_beat  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    out_d = '0;
    if (pop) begin
      for (int c = 0; c < NUM_AVST_CH; c++) begin
        out_d[c].valid = rd_beat[c].valid;
        out_d[c].sop   = rd_beat[c].valid & rd_beat[c].sop;
        out_d[c].eop   = rd_beat[c].valid & rd_beat[c].eop;
        out_d[c].hdr   = rd_beat[c].hdr;
        out_d[c].data  = rd_beat[c].payload;
      end
    end
  end

  always_ff @(posedge avl_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= axis_tx_st.tdata;
    end
  end

  always_ff @(posedge avl_clk or negedge avl_rst_n) begin
    if (!avl_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rdy_pipe_q <= '0;
      out_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rdy_pipe_q <= rdy_pipe_d;
      out_q      <= out_d;
    end
  end

  assign avl_tx_st = out_q;

`ifdef PCIE_TX_FRAME_CHECK_EN
  typedef enum logic {
    IDLE,
    IN_PKT
  } fr_state_e;

  fr_state_e fr_st_q, fr_st_d;
  logic      fr_err_q;
  logic      fr_hit;

  // Channels are walked low to high so a beat may close and reopen.
  always_comb begin
    fr_st_d = fr_st_q;
    fr_hit  = 1'b0;
    if (accept) begin
      for (int c = 0; c < NUM_AVST_CH; c++) begin
        if (axis_tx_st.tdata[c].valid) begin
          if (axis_tx_st.tdata[c].sop) begin
            if (fr_st_d == IN_PKT) fr_hit = 1'b1;
            fr_st_d = axis_tx_st.tdata[c].eop ? IDLE : IN_PKT;
          end else begin
            if (fr_st_d == IDLE) fr_hit = 1'b1;
            if (axis_tx_st.tdata[c].eop) fr_st_d = IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge avl_clk or negedge avl_rst_n) begin
    if (!avl_rst_n) begin
      fr_st_q  <= IDLE;
      fr_err_q <= 1'b0;
    end else begin
      fr_st_q <= fr_st_d;
      if (fr_hit) fr_err_q <= 1'b1;
    end
  end

  assign frame_err = fr_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule
